// File: rtl/ldpc_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_pkg
// Shared definitions for the LDPC datapath (encoder, serializer, and a
// future deserializer): default code dimensions, default serializer beat
// width, and the serializer state encoding.
// ---------------------------------------------------------------------------
package ldpc_pkg;

  localparam int LDPC_N     = 2304;  // codeword length in bits
  localparam int LDPC_K     = 1152;  // information length in bits
  localparam int LDPC_OUT_W = 8;     // serializer beat width in bits

  // Serializer state encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Number of beats needed to carry an n-bit codeword w bits at a time
  function automatic int ser_beats(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/codeword_serializer.sv
// ---------------------------------------------------------------------------
// codeword_serializer
// Captures one N-bit parallel codeword from the LDPC encoder and streams it
// out OUT_W bits per beat, LSB first, over a valid/ready handshake. The next
// codeword can be captured in the same cycle the last beat is accepted, so
// consecutive frames run without a bubble.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active low
//   cw_in      in   [N]      codeword from encoder
//   cw_valid   in            cw_in valid this cycle
//   cw_ready   out           block captures cw_in this cycle (if cw_valid)
//   out_data   out  [OUT_W]  current beat
//   out_valid  out           out_data valid
//   out_ready  in            downstream accepts the beat
//   out_last   out           current beat is the final beat of the frame
//   busy       out           a frame is loaded and not fully sent
//   frame_cnt  out  [FRAME_CNT_BITS] completed frames, wraps
// ---------------------------------------------------------------------------
module codeword_serializer
  import ldpc_pkg::*;
#(
  parameter int N              = LDPC_N,
  parameter int OUT_W          = LDPC_OUT_W,
  parameter int BEAT_BITS      = 9,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              cw_in,
  input  logic                      cw_valid,
  output logic                      cw_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic [FRAME_CNT_BITS-1:0] frame_cnt
);

  localparam int NUM_BEATS = ser_beats(N, OUT_W);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NUM_BEATS - 1);

  // Elaboration-time parameter sanity checks
  generate
    if ((N % OUT_W) != 0) begin : g_bad_width
      $error("codeword_serializer: N must be a multiple of OUT_W");
    end
    if ((2 ** BEAT_BITS) < NUM_BEATS) begin : g_bad_beat_bits
      $error("codeword_serializer: BEAT_BITS too small for N/OUT_W beats");
    end
  endgenerate

  ser_state_e                state_q, state_d;
  logic [N-1:0]              buf_q, buf_d;
  logic [BEAT_BITS-1:0]      beat_q, beat_d;
  logic [FRAME_CNT_BITS-1:0] frame_q, frame_d;

  logic sending_s;
  logic last_s;
  logic xfer_s;

  // Output views of registered state; out_valid never looks at out_ready
  assign sending_s = (state_q == ST_SEND);
  assign last_s    = sending_s && (beat_q == LAST_BEAT);
  assign xfer_s    = sending_s && out_ready;

  assign out_valid = sending_s;
  assign out_last  = last_s;
  assign out_data  = buf_q[OUT_W-1:0];
  assign busy      = sending_s;
  assign frame_cnt = frame_q;
  // Idle always accepts; while sending, only on the accepted last beat
  assign cw_ready  = sending_s ? (last_s && out_ready) : 1'b1;

  // Next-state, buffer, beat counter and frame counter logic
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    beat_d  = beat_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: begin
        if (cw_valid) begin
          buf_d   = cw_in;
          beat_d  = '0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          if (last_s) begin
            frame_d = frame_q + FRAME_CNT_BITS'(1);
            beat_d  = '0;
            if (cw_valid) begin
              // Back-to-back frame: reload in place, stay in SEND
              buf_d   = cw_in;
              state_d = ST_SEND;
            end else begin
              buf_d   = buf_q >> OUT_W;
              state_d = ST_IDLE;
            end
          end else begin
            buf_d  = buf_q >> OUT_W;
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      beat_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
    end
  end

endmodule
